// File: rtl/bram_stream_reader.sv
// Streams LEN consecutive words from BRAM port B as a valid/ready stream via a 2-entry FIFO.
// Optional feature macro BRAM_RD_PERF_EN adds a saturating stall_cycles counter output.
module bram_stream_reader #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  b_we,
  output logic [ADDR_WIDTH-1:0] b_addr,
  output logic [DATA_WIDTH-1:0] b_wdata,
  input  logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
`ifdef BRAM_RD_PERF_EN
  output logic                  out_last,
  output logic [31:0]           stall_cycles
`else
  output logic                  out_last
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   rem_issue;
  logic [ADDR_WIDTH:0]   rem_pop;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            fifo_count;
  logic                  accept;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic                  head_is_last;

  assign accept       = (state == S_IDLE) && start;
  assign pop          = out_valid && out_ready;
  assign push         = inflight;
  assign head_is_last = (rem_pop == (ADDR_WIDTH+1)'(1));

  // A read may only issue if its data is guaranteed a FIFO slot when it returns next cycle.
  assign issue = (state == S_RUN) && (rem_issue != '0) &&
                 (({1'b0, fifo_count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign b_we      = 1'b0;
  assign b_wdata   = '0;
  assign b_addr    = issue ? cur_addr : addr_q;
  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = fifo_mem[rd_ptr];
  assign out_last  = out_valid && head_is_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cur_addr  <= '0;
      addr_q    <= '0;
      rem_issue <= '0;
      rem_pop   <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        addr_q    <= cur_addr;
        cur_addr  <= cur_addr + 1'b1;
        rem_issue <= rem_issue - 1'b1;
      end
      if (pop) rem_pop <= rem_pop - 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            cur_addr  <= base_addr;
            rem_issue <= len;
            rem_pop   <= len;
            state     <= (len == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN:   if (pop && head_is_last) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Two-entry FIFO; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= b_rdata;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (push && !pop)      fifo_count <= fifo_count + 2'd1;
      else if (pop && !push) fifo_count <= fifo_count - 2'd1;
    end
  end

`ifdef BRAM_RD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      stall_cycles <= '0;
    end else if (busy && out_valid && !out_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Randomized scoreboard bench for bram_stream_reader with a registered-read BRAM model.
// Exercises the BRAM_RD_PERF_EN stall counter when that macro is defined.
module tb_bram_stream_reader;
  localparam int AW = 18;
  localparam int DW = 32;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic [DW-1:0] b_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
`ifdef BRAM_RD_PERF_EN
  logic [31:0]   stall_cycles;
`endif

  logic [DW-1:0] mem [0:(1<<AW)-1];
  word_t         exp_q[$];
  logic [AW-1:0] addr_seq[$];
  int            tests_run = 0;
  int            tests_failed = 0;
  int            hs_count = 0;
  int            done_seen = 0;
  int            valid_cnt = 0;
  int            range_bad = 0;
  int            ready_mode = 0;
  logic          manual_ready = 1'b1;
  logic          addr_watch = 1'b0;
  logic          range_en = 1'b0;
  logic [AW-1:0] range_lo = '0;
  logic [AW-1:0] range_hi = '0;

  bram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data),
`ifdef BRAM_RD_PERF_EN
    .out_last(out_last), .stall_cycles(stall_cycles)
`else
    .out_last(out_last)
`endif
  );

  always #5 clk = ~clk;

  // BRAM port B: data for an address appears the cycle after it is presented.
  always @(posedge clk) b_rdata <= mem[b_addr];

  always @(posedge clk) begin
    int pat_idx;
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      2: begin
        out_ready = (pat_idx % 3 == 0);
        pat_idx++;
      end
      default: out_ready = manual_ready;
    endcase
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks hold-while-stalled.
  always @(negedge clk) begin
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [AW-1:0] prev_addr;
    word_t         w;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("stall_valid_held", 64'(out_valid), 64'd1);
        checkOutput("stall_data_stable", 64'(out_data), 64'(prev_data));
        checkOutput("stall_last_stable", 64'(out_last), 64'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_word: got 0x%0h, expected no word at %0t", out_data, $time);
        end else begin
          w = exp_q.pop_front();
          checkOutput("stream_data", 64'(out_data), 64'(w.data));
          checkOutput("stream_last", 64'(out_last), 64'(w.last));
        end
        hs_count++;
      end
      if (out_valid) valid_cnt++;
      if (done) done_seen++;
      if (range_en && busy && (b_addr < range_lo || b_addr > range_hi)) range_bad++;
      if (addr_watch && b_addr != prev_addr) addr_seq.push_back(b_addr);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
    prev_addr = b_addr;
  end

  // Reference model: word i of a transfer is mem[(base+i) mod 2^AW], last when i == len-1.
  task automatic applyStimulus(input logic [AW-1:0] base, input int n);
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      word_t w;
      a = base + AW'(i);
      w.data = mem[a];
      w.last = (i == n - 1);
      exp_q.push_back(w);
    end
    start     = 1'b1;
    base_addr = base;
    len       = (AW+1)'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int first_cycle, input int budget, output int cyc);
    cyc = -1;
    for (int c = first_cycle; c < first_cycle + budget; c++) begin
      @(negedge clk);
      if (done) begin
        cyc = c;
        return;
      end
    end
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL done_timeout: got no done, expected done within %0d cycles", budget);
  endtask

  task automatic fillRandom(input logic [AW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      a = base + AW'(i);
      mem[a] = $urandom;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_out_last"}, 64'(out_last), 64'd0);
    checkOutput({tag, "_out_data"}, 64'(out_data), 64'd0);
    checkOutput({tag, "_b_addr"}, 64'(b_addr), 64'd0);
    checkOutput({tag, "_b_we"}, 64'(b_we), 64'd0);
    checkOutput({tag, "_b_wdata"}, 64'(b_wdata), 64'd0);
  endtask

  initial begin
    int cyc;
    int hs0;
    int done0;
    int valid0;
    logic [AW-1:0] addr0;
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    len = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkResetValues("reset");

    // Basic transfer at full rate with exact latency.
    for (int i = 0; i < 8; i++) mem[100 + i] = DW'(i * 3);
    ready_mode = 0;
    applyStimulus(AW'(100), 8);
    @(negedge clk);
    checkOutput("c1_b_addr", 64'(b_addr), 64'd100);
    checkOutput("c1_busy", 64'(busy), 64'd1);
    checkOutput("c1_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    checkOutput("c2_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    checkOutput("c3_out_valid", 64'(out_valid), 64'd1);
    checkOutput("c3_out_data", 64'(out_data), 64'd0);
    waitDone(4, 50, cyc);
    checkOutput("t1_done_cycle", 64'(cyc), 64'd11);
    checkOutput("t1_busy_in_done", 64'(busy), 64'd1);
    @(negedge clk);
    checkOutput("t1_busy_after", 64'(busy), 64'd0);
    checkOutput("t1_done_pulse", 64'(done), 64'd0);
    checkOutput("t1_queue_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure pattern 1,0,0,...; address must stay within the window.
    #1;
    hs0 = hs_count;
    range_lo = AW'(100);
    range_hi = AW'(107);
    range_en = 1'b1;
    ready_mode = 2;
    applyStimulus(AW'(100), 8);
    waitDone(1, 200, cyc);
    #1;
    range_en = 1'b0;
    checkOutput("t2_handshakes", 64'(hs_count - hs0), 64'd8);
    checkOutput("t2_queue_drained", 64'(exp_q.size()), 64'd0);
    checkOutput("t2_addr_range_violations", 64'(range_bad), 64'd0);

    // Zero-length transfer.
    ready_mode = 0;
    @(negedge clk);
    addr0 = b_addr;
    valid0 = valid_cnt;
    applyStimulus(AW'(5), 0);
    waitDone(1, 10, cyc);
    checkOutput("t3_done_cycle", 64'(cyc), 64'd1);
    checkOutput("t3_b_addr_held", 64'(b_addr), 64'(addr0));
    repeat (3) @(negedge clk);
    #1;
    checkOutput("t3_no_valid", 64'(valid_cnt - valid0), 64'd0);
    checkOutput("t3_busy_after", 64'(busy), 64'd0);

    // Address wrap at the top of the address space.
    fillRandom(AW'((1 << AW) - 1), 3);
    addr_seq.delete();
    addr_watch = 1'b1;
    applyStimulus(AW'((1 << AW) - 1), 3);
    waitDone(1, 50, cyc);
    #1;
    addr_watch = 1'b0;
    checkOutput("t4_addr_seq_len", 64'(addr_seq.size()), 64'd3);
    if (addr_seq.size() == 3) begin
      checkOutput("t4_addr0", 64'(addr_seq[0]), 64'h3FFFF);
      checkOutput("t4_addr1", 64'(addr_seq[1]), 64'h00000);
      checkOutput("t4_addr2", 64'(addr_seq[2]), 64'h00001);
    end
    checkOutput("t4_queue_drained", 64'(exp_q.size()), 64'd0);

    // Reset after four words aborts without done.
    fillRandom(AW'(200), 8);
    hs0 = hs_count;
    applyStimulus(AW'(200), 8);
    for (int c = 0; c < 50 && (hs_count - hs0) < 4; c++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("t5_words_before_reset", 64'(hs_count - hs0), 64'd4);
    @(posedge clk);
    #1 rst = 1'b1;
    done0 = done_seen;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checkResetValues("t5_after_reset");
    repeat (3) @(negedge clk);
    #1;
    checkOutput("t5_no_done", 64'(done_seen - done0), 64'd0);

    // Fresh transfer with a start pulse during RUN that must be ignored.
    fillRandom(AW'(300), 6);
    fillRandom(AW'(500), 3);
    hs0 = hs_count;
    ready_mode = 1;
    applyStimulus(AW'(300), 6);
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = AW'(500);
    len = (AW+1)'(3);
    @(posedge clk);
    #1 start = 1'b0;
    waitDone(3, 200, cyc);
    repeat (4) @(negedge clk);
    #1;
    checkOutput("t5_restart_handshakes", 64'(hs_count - hs0), 64'd6);
    checkOutput("t5_restart_queue_drained", 64'(exp_q.size()), 64'd0);

    // Randomized transfers under random backpressure.
    for (int t = 0; t < 6; t++) begin
      logic [AW-1:0] b;
      int n;
      b = AW'($urandom_range(0, (1 << AW) - 1));
      n = $urandom_range(1, 24);
      fillRandom(b, n);
      hs0 = hs_count;
      applyStimulus(b, n);
      waitDone(1, 400, cyc);
      #1;
      checkOutput("rand_handshakes", 64'(hs_count - hs0), 64'(n));
      checkOutput("rand_queue_drained", 64'(exp_q.size()), 64'd0);
    end

`ifdef BRAM_RD_PERF_EN
    // Five forced stall cycles with a word waiting.
    fillRandom(AW'(600), 2);
    manual_ready = 1'b0;
    ready_mode = 3;
    @(posedge clk);
    applyStimulus(AW'(600), 2);
    for (int c = 0; c < 20 && !out_valid; c++) @(negedge clk);
    for (int s = 1; s < 5; s++) @(negedge clk);
    manual_ready = 1'b1;
    waitDone(1, 50, cyc);
    checkOutput("t6_stall_cycles", 64'(stall_cycles), 64'd5);
    ready_mode = 0;
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
